// File: rtl/game_pkg.sv
// Shared fixed-point constants, FSM state type and reset layout for the dog physics core.
package game_pkg;

  localparam int FRAC_BITS = 8;
  localparam int VEL_W     = 10;
  localparam int POS_IW    = 12;

  localparam logic signed [VEL_W-1:0] VEL_MIN = 10'sh200;
  localparam logic signed [VEL_W-1:0] VEL_MAX = 10'sh1FF;
  localparam logic signed [VEL_W:0]   SUM_MIN = -11'sd512;
  localparam logic signed [VEL_W:0]   SUM_MAX = 11'sd511;

  localparam int RST_X0 = 100;
  localparam int RST_DX = 64;
  localparam int RST_Y0 = 100;
  localparam int RST_DY = 32;
  localparam logic signed [VEL_W-1:0] RST_VX = 10'sd384;
  localparam logic signed [VEL_W-1:0] RST_VY = 10'sd256;

  typedef enum logic [1:0] {IDLE, MOVE, COLLIDE, DONE} state_e;

  function automatic logic signed [VEL_W-1:0] sat_add(
    input logic signed [VEL_W-1:0] a,
    input logic signed [VEL_W-1:0] b
  );
    logic signed [VEL_W:0] s;
    s = {a[VEL_W-1], a} + {b[VEL_W-1], b};
    if (s > SUM_MAX) return VEL_MAX;
    else if (s < SUM_MIN) return VEL_MIN;
    else return s[VEL_W-1:0];
  endfunction

endpackage

// File: rtl/dog_integrator.sv
// One axis of one dog for one frame: integer step from the old velocity, friction, wall bounce.
module dog_integrator import game_pkg::*; #(
  parameter int P_W      = 10,
  parameter int LIMIT    = 592,
  parameter int FRICTION = 251
) (
  input  logic [P_W-1:0]          p_i,
  input  logic signed [VEL_W-1:0] v_i,
  output logic [P_W-1:0]          p_o,
  output logic signed [VEL_W-1:0] v_o
);
  localparam int PROD_W = 2 * VEL_W;
  localparam logic signed [POS_IW-1:0] LIM_S  = POS_IW'(LIMIT);
  localparam logic [P_W-1:0]           LIM_P  = P_W'(LIMIT);
  localparam logic signed [PROD_W-1:0] FRIC_S = PROD_W'(FRICTION);

  logic signed [POS_IW-1:0] p_ext, v_ext, p_sum;
  logic signed [PROD_W-1:0] v_wide, prod;
  logic signed [VEL_W-1:0]  v_fr, v_half;
  logic                     unused_prod;

  always_comb begin
    p_ext  = {{(POS_IW-P_W){1'b0}}, p_i};
    v_ext  = {{(POS_IW-VEL_W){v_i[VEL_W-1]}}, v_i};
    p_sum  = p_ext + (v_ext >>> FRAC_BITS);
    v_wide = {{VEL_W{v_i[VEL_W-1]}}, v_i};
    prod   = v_wide * FRIC_S;
    // Bits [17:8] of the product equal the arithmetic >>>8 truncated to velocity width.
    v_fr   = prod[FRAC_BITS +: VEL_W];
    v_half = v_fr >>> 1;
    p_o    = p_sum[P_W-1:0];
    v_o    = v_fr;
    if (p_sum[POS_IW-1]) begin
      p_o = '0;
      v_o = -v_half;
    end else if (p_sum > LIM_S) begin
      p_o = LIM_P;
      v_o = -v_half;
    end
  end

  assign unused_prod = ^{prod[FRAC_BITS-1:0], prod[PROD_W-1:FRAC_BITS+VEL_W]};

endmodule

// File: rtl/game_core_multi.sv
// Multi-dog physics core: one shared x/y integrator walks the dogs, then optional pair collisions.
// Define DOG_COLLIDE_EN to build the COLLIDE state, pair swap logic and hit counters.
module game_core_multi import game_pkg::*; #(
  parameter int N_DOGS   = 4,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int BOX_W    = 48,
  parameter int BOX_H    = 32,
  parameter int FRICTION = 251
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic                      kick_valid,
  output logic                      kick_ready,
  input  logic [2:0]                kick_id,
  input  logic signed [VEL_W-1:0]   kick_dvx,
  input  logic signed [VEL_W-1:0]   kick_dvy,
  output logic [N_DOGS*10-1:0]      posx_flat,
  output logic [N_DOGS*9-1:0]       posy_flat,
  output logic [N_DOGS*VEL_W-1:0]   velx_flat,
  output logic [N_DOGS*VEL_W-1:0]   vely_flat,
  output logic [N_DOGS*8-1:0]       hits_flat,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);
  state_e                  state_q;
  logic [2:0]              idx_q;
  logic                    frame_done_q, overrun_q, kick_fire;
  logic [9:0]              mv_px, px_d;
  logic [8:0]              mv_py, py_d;
  logic signed [VEL_W-1:0] mv_vx, mv_vy, vx_d, vy_d;

  assign busy       = (state_q != IDLE);
  assign kick_ready = (state_q == IDLE);
  assign kick_fire  = kick_valid && kick_ready;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

  always_comb begin
    mv_px = '0;
    mv_py = '0;
    mv_vx = '0;
    mv_vy = '0;
    for (int k = 0; k < N_DOGS; k++) begin
      if (idx_q == 3'(k)) begin
        mv_px = posx_flat[k*10 +: 10];
        mv_py = posy_flat[k*9 +: 9];
        mv_vx = velx_flat[k*VEL_W +: VEL_W];
        mv_vy = vely_flat[k*VEL_W +: VEL_W];
      end
    end
  end

  dog_integrator #(.P_W(10), .LIMIT(SCREEN_W - BOX_W), .FRICTION(FRICTION)) u_int_x (
    .p_i(mv_px), .v_i(mv_vx), .p_o(px_d), .v_o(vx_d)
  );
  dog_integrator #(.P_W(9), .LIMIT(SCREEN_H - BOX_H), .FRICTION(FRICTION)) u_int_y (
    .p_i(mv_py), .v_i(mv_vy), .p_o(py_d), .v_o(vy_d)
  );

`ifdef DOG_COLLIDE_EN
  logic [2:0]              ci_q, cj_q;
  logic [9:0]              xi, xj;
  logic [8:0]              yi, yj;
  logic signed [VEL_W-1:0] vxi, vyi, vxj, vyj;
  logic signed [11:0]      dx, dy;
  logic [11:0]             adx, ady;
  logic                    overlap;

  always_comb begin
    xi = '0; yi = '0; vxi = '0; vyi = '0;
    xj = '0; yj = '0; vxj = '0; vyj = '0;
    for (int k = 0; k < N_DOGS; k++) begin
      if (ci_q == 3'(k)) begin
        xi  = posx_flat[k*10 +: 10];
        yi  = posy_flat[k*9 +: 9];
        vxi = velx_flat[k*VEL_W +: VEL_W];
        vyi = vely_flat[k*VEL_W +: VEL_W];
      end
      if (cj_q == 3'(k)) begin
        xj  = posx_flat[k*10 +: 10];
        yj  = posy_flat[k*9 +: 9];
        vxj = velx_flat[k*VEL_W +: VEL_W];
        vyj = vely_flat[k*VEL_W +: VEL_W];
      end
    end
    dx  = $signed({2'b00, xi}) - $signed({2'b00, xj});
    dy  = $signed({3'b000, yi}) - $signed({3'b000, yj});
    adx = dx[11] ? -dx : dx;
    ady = dy[11] ? -dy : dy;
    overlap = (state_q == COLLIDE) && (adx < 12'(BOX_W)) && (ady < 12'(BOX_H));
  end
`endif

  for (genvar gi = 0; gi < N_DOGS; gi++) begin : g_dog
    logic [9:0]              posx_q;
    logic [8:0]              posy_q;
    logic signed [VEL_W-1:0] velx_q, vely_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        posx_q <= 10'(RST_X0 + RST_DX * gi);
        posy_q <= 9'(RST_Y0 + RST_DY * gi);
        velx_q <= (gi % 2 == 0) ? RST_VX : -RST_VX;
        vely_q <= RST_VY;
      end else if (kick_fire && kick_id == 3'(gi)) begin
        velx_q <= sat_add(velx_q, kick_dvx);
        vely_q <= sat_add(vely_q, kick_dvy);
      end else if (state_q == MOVE && idx_q == 3'(gi)) begin
        posx_q <= px_d;
        posy_q <= py_d;
        velx_q <= vx_d;
        vely_q <= vy_d;
      end
`ifdef DOG_COLLIDE_EN
      else if (overlap && ci_q == 3'(gi)) begin
        velx_q <= vxj;
        vely_q <= vyj;
      end else if (overlap && cj_q == 3'(gi)) begin
        velx_q <= vxi;
        vely_q <= vyi;
      end
`endif
    end

    assign posx_flat[gi*10 +: 10]       = posx_q;
    assign posy_flat[gi*9 +: 9]         = posy_q;
    assign velx_flat[gi*VEL_W +: VEL_W] = velx_q;
    assign vely_flat[gi*VEL_W +: VEL_W] = vely_q;

`ifdef DOG_COLLIDE_EN
    logic [7:0] hits_q;
    always_ff @(posedge clk) begin
      if (rst) hits_q <= '0;
      else if (overlap && (ci_q == 3'(gi) || cj_q == 3'(gi)) && hits_q != 8'hFF)
        hits_q <= hits_q + 8'd1;
    end
    assign hits_flat[gi*8 +: 8] = hits_q;
`else
    assign hits_flat[gi*8 +: 8] = 8'h00;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef DOG_COLLIDE_EN
      ci_q         <= 3'd0;
      cj_q         <= 3'd1;
`endif
    end else begin
      frame_done_q <= 1'b0;
      overrun_q    <= frame_tick && (state_q != IDLE);
      case (state_q)
        IDLE: if (frame_tick) begin
          state_q <= MOVE;
          idx_q   <= '0;
        end
        MOVE: if (idx_q == 3'(N_DOGS - 1)) begin
`ifdef DOG_COLLIDE_EN
          if (N_DOGS > 1) begin
            state_q <= COLLIDE;
            ci_q    <= 3'd0;
            cj_q    <= 3'd1;
          end else begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end
`else
          state_q      <= DONE;
          frame_done_q <= 1'b1;
`endif
        end else begin
          idx_q <= idx_q + 3'd1;
        end
`ifdef DOG_COLLIDE_EN
        // Pairs advance (i, j) lexicographically; the last pair is (N-2, N-1).
        COLLIDE: if (cj_q == 3'(N_DOGS - 1)) begin
          if (ci_q == 3'(N_DOGS - 2)) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end else begin
            ci_q <= ci_q + 3'd1;
            cj_q <= ci_q + 3'd2;
          end
        end else begin
          cj_q <= cj_q + 3'd1;
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_core_multi.sv
// Directed bench for game_core_multi: three instances (1 dog narrow screen, 2 dogs wide boxes, 4 dogs).
module tb_game_core_multi;

`ifdef DOG_COLLIDE_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [2:0]        tick_v;
  logic              kv;
  logic [2:0]        kid;
  logic signed [9:0] kdx, kdy;

  wire [2:0]  done_v, busy_v, ovr_v;
  wire        kr1, kr2, kr4;
  wire [9:0]  px1, vx1, vy1;
  wire [8:0]  py1;
  wire [7:0]  h1;
  wire [19:0] px2, vx2, vy2;
  wire [17:0] py2;
  wire [15:0] h2;
  wire [39:0] px4, vx4, vy4;
  wire [35:0] py4;
  wire [31:0] h4;

  int n_checks = 0;
  int n_fail   = 0;

  game_core_multi #(.N_DOGS(1), .SCREEN_W(160)) u_d1 (
    .clk(clk), .rst(rst), .frame_tick(tick_v[0]),
    .kick_valid(1'b0), .kick_ready(kr1), .kick_id(3'd0), .kick_dvx(10'sd0), .kick_dvy(10'sd0),
    .posx_flat(px1), .posy_flat(py1), .velx_flat(vx1), .vely_flat(vy1), .hits_flat(h1),
    .busy(busy_v[0]), .frame_done(done_v[0]), .overrun(ovr_v[0])
  );

  game_core_multi #(.N_DOGS(2), .BOX_W(80), .BOX_H(40)) u_d2 (
    .clk(clk), .rst(rst), .frame_tick(tick_v[1]),
    .kick_valid(1'b0), .kick_ready(kr2), .kick_id(3'd0), .kick_dvx(10'sd0), .kick_dvy(10'sd0),
    .posx_flat(px2), .posy_flat(py2), .velx_flat(vx2), .vely_flat(vy2), .hits_flat(h2),
    .busy(busy_v[1]), .frame_done(done_v[1]), .overrun(ovr_v[1])
  );

  game_core_multi #(.N_DOGS(4)) u_d4 (
    .clk(clk), .rst(rst), .frame_tick(tick_v[2]),
    .kick_valid(kv), .kick_ready(kr4), .kick_id(kid), .kick_dvx(kdx), .kick_dvy(kdy),
    .posx_flat(px4), .posy_flat(py4), .velx_flat(vx4), .vely_flat(vy4), .hits_flat(h4),
    .busy(busy_v[2]), .frame_done(done_v[2]), .overrun(ovr_v[2])
  );

  function automatic int sx(input logic [9:0] v);
    return int'($signed(v));
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_d4();
    for (int i = 0; i < 4; i++) begin
      check_eq("rst_posx", int'(px4[i*10 +: 10]), 100 + 64*i);
      check_eq("rst_posy", int'(py4[i*9 +: 9]), 100 + 32*i);
      check_eq("rst_velx", sx(vx4[i*10 +: 10]), (i % 2 == 0) ? 384 : -384);
      check_eq("rst_vely", sx(vy4[i*10 +: 10]), 256);
      check_eq("rst_hits", int'(h4[i*8 +: 8]), 0);
    end
  endtask

  task automatic kick(input int id, input int dx, input int dy);
    @(negedge clk);
    kv = 1'b1; kid = 3'(id); kdx = 10'(dx); kdy = 10'(dy);
    @(negedge clk);
    kv = 1'b0;
    $display("kick id=%0d dvx=%0d dvy=%0d -> velx0=%0d", id, dx, dy, sx(vx4[9:0]));
  endtask

  // Tick instance u (optionally with a simultaneous kick and a mid-frame dropped tick)
  // and measure cycles from the tick cycle to the frame_done cycle.
  task automatic run_frame(input int u, input int exp_lat, input bit ovr_test,
                           input bit kick_en, input int k_id, input int k_dx, input int k_dy);
    int lat;
    bit seen;
    @(negedge clk);
    tick_v[u] = 1'b1;
    if (kick_en) begin
      kv = 1'b1; kid = 3'(k_id); kdx = 10'(k_dx); kdy = 10'(k_dy);
    end
    @(negedge clk);
    tick_v[u] = 1'b0;
    kv = 1'b0;
    lat = 1;
    seen = 1'b0;
    check_eq("busy_after_tick", int'(busy_v[u]), 1);
    while (!seen && lat < 64) begin
      if (done_v[u]) begin
        seen = 1'b1;
      end else begin
        tick_v[u] = ovr_test && (lat == 2);
        @(negedge clk);
        lat++;
        if (ovr_test && lat == 3) check_eq("overrun_pulse", int'(ovr_v[u]), 1);
        if (ovr_test && lat == 4) check_eq("overrun_clear", int'(ovr_v[u]), 0);
      end
    end
    tick_v[u] = 1'b0;
    check_eq("frame_done_seen", int'(seen), 1);
    check_eq("frame_latency", lat, exp_lat);
    @(negedge clk);
    check_eq("frame_done_one_cycle", int'(done_v[u]), 0);
    check_eq("idle_after_done", int'(busy_v[u]), 0);
    $display("frame inst=%0d latency=%0d expected=%0d", u, lat, exp_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int clamp_f;
    bit any_done;
    rst = 1'b1; tick_v = '0; kv = 1'b0; kid = '0; kdx = '0; kdy = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_reset_d4();
    check_eq("rst_busy", int'(busy_v), 0);
    check_eq("rst_done", int'(done_v), 0);
    check_eq("rst_overrun", int'(ovr_v), 0);
    check_eq("rst_kick_ready", int'(kr4), 1);
    check_eq("rst_d1_posx", int'(px1), 100);

    // Single dog, one frame
    run_frame(0, 2, 1'b0, 1'b0, 0, 0, 0);
    check_eq("d1_posx", int'(px1), 101);
    check_eq("d1_posy", int'(py1), 101);
    check_eq("d1_velx", sx(vx1), 376);
    check_eq("d1_vely", sx(vy1), 251);
    check_eq("d1_hits", int'(h1), 0);

    // Two overlapping dogs
    run_frame(1, COLL ? 4 : 3, 1'b0, 1'b0, 0, 0, 0);
    check_eq("d2_posx0", int'(px2[9:0]), 101);
    check_eq("d2_posx1", int'(px2[19:10]), 162);
    check_eq("d2_posy1", int'(py2[17:9]), 133);
    check_eq("d2_velx0", sx(vx2[9:0]), COLL ? -377 : 376);
    check_eq("d2_velx1", sx(vx2[19:10]), COLL ? 376 : -377);
    check_eq("d2_hits0", int'(h2[7:0]), COLL ? 1 : 0);
    check_eq("d2_hits1", int'(h2[15:8]), COLL ? 1 : 0);

    // Kicks: positive saturation, out-of-range id, negative saturation
    kick(0, 511, 0);
    check_eq("kick_sat_pos1", sx(vx4[9:0]), 511);
    kick(0, 511, 0);
    check_eq("kick_sat_pos2", sx(vx4[9:0]), 511);
    check_eq("kick_vely0", sx(vy4[9:0]), 256);
    kick(7, 200, 200);
    for (int i = 0; i < 4; i++) begin
      check_eq("kick_id7_velx", sx(vx4[i*10 +: 10]), (i == 0) ? 511 : ((i % 2 == 0) ? 384 : -384));
      check_eq("kick_id7_vely", sx(vy4[i*10 +: 10]), 256);
    end
    kick(0, -512, 0);
    check_eq("kick_sub", sx(vx4[9:0]), -1);
    kick(0, -512, 0);
    check_eq("kick_sat_neg", sx(vx4[9:0]), -512);

    // Kick together with tick, plus a dropped tick mid-frame
    run_frame(2, COLL ? 11 : 5, 1'b1, 1'b1, 1, 0, -100);
    check_eq("d4_posx0", int'(px4[9:0]), 98);
    check_eq("d4_velx0", sx(vx4[9:0]), -502);
    check_eq("d4_posy0", int'(py4[8:0]), 101);
    check_eq("d4_vely0", sx(vy4[9:0]), 251);
    check_eq("d4_posx1", int'(px4[19:10]), 162);
    check_eq("d4_velx1", sx(vx4[19:10]), -377);
    check_eq("d4_posy1", int'(py4[17:9]), 132);
    check_eq("d4_vely1", sx(vy4[19:10]), 152);
    check_eq("d4_posx2", int'(px4[29:20]), 229);
    check_eq("d4_hits0", int'(h4[7:0]), 0);

    // Right wall on a 160-wide screen: limit is 112
    clamp_f = 0;
    for (int f = 2; f <= 40 && clamp_f == 0; f++) begin
      run_frame(0, 2, 1'b0, 1'b0, 0, 0, 0);
      check_eq("d1_x_bound", (int'(px1) <= 112) ? 1 : 0, 1);
      if (vx1[9]) clamp_f = f;
    end
    check_eq("clamp_frame", clamp_f, 13);
    check_eq("clamp_posx", int'(px1), 112);
    check_eq("clamp_velx", sx(vx1), -145);

    // Reset in the middle of MOVE
    @(negedge clk);
    tick_v[2] = 1'b1;
    @(negedge clk);
    tick_v[2] = 1'b0;
    check_eq("ready_while_busy", int'(kr4), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_d4();
    check_eq("midrst_busy", int'(busy_v[2]), 0);
    check_eq("midrst_done", int'(done_v[2]), 0);
    check_eq("midrst_d1_posx", int'(px1), 100);
    any_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[2]) any_done = 1'b1;
    end
    check_eq("no_done_after_rst", int'(any_done), 0);
    check_eq("idle_after_rst", int'(busy_v[2]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_core_multi.md
GAME_CORE_MULTI -- requirements
Module: game_core_multi

Interface
REQ-001 SHALL provide parameter N_DOGS, default 4, number of dogs (legal 1..8).
REQ-002 SHALL provide parameters SCREEN_W 640, SCREEN_H 480, BOX_W 48, BOX_H 32, sizing the play field and dog box in pixels.
REQ-003 SHALL provide parameter FRICTION, default 251, per-frame velocity multiplier in 1/256 units (legal 0..256).
REQ-004 clk  in  1  sole clock; all logic is rising-edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 frame_tick  in  1  one-cycle pulse that starts a physics frame.
REQ-007 kick_valid / kick_ready  in / out  1 / 1  velocity-impulse handshake.
REQ-008 kick_id / kick_dvx / kick_dvy  in  3 / 10 / 10  target dog; signed impulses in Q2.8.
REQ-009 posx_flat / posy_flat  out  N_DOGS*10 / N_DOGS*9  dog i position at slice i.
REQ-010 velx_flat / vely_flat  out  N_DOGS*10 each  signed Q2.8 velocities.
REQ-011 hits_flat  out  N_DOGS*8  per-dog collision counters.
REQ-012 busy / frame_done / overrun  out  1 / 1 / 1  frame in progress; one-cycle end pulse; one-cycle dropped-tick pulse.

Function
REQ-013 FSM SHALL have states IDLE, MOVE, COLLIDE, DONE; reset state IDLE; busy=1 outside IDLE.
REQ-014 IDLE with frame_tick -> MOVE next cycle; MOVE processes dog idx 0..N_DOGS-1, one per cycle.
REQ-015 After the last dog, MOVE -> COLLIDE (or DONE if collision compiled out).
REQ-016 COLLIDE visits pairs (i<j) in lexicographic order, one per cycle, then -> DONE; DONE asserts frame_done for one cycle -> IDLE.
REQ-017 Tick at cycle t: frame_done at t+N_DOGS+P+1, P = N_DOGS*(N_DOGS-1)/2, or 0 without collision.
REQ-018 MOVE per dog: p' = p + (v>>>8) using pre-update v; v' = (v*FRICTION)>>>8, arithmetic shift, 20-bit signed product.
REQ-019 Bounce: if p' < 0 then p'=0; if p' > SCREEN_W-BOX_W (x) or SCREEN_H-BOX_H (y) then clamp to that limit; in either case v' = -(v'>>>1).
REQ-020 Position arithmetic SHALL use 12-bit signed intermediates; no wrap-around on any input.
REQ-021 kick_ready = 1 only in IDLE; on accept vel[id] += dv, saturated to [-512, 511].
REQ-022 A kick with kick_id >= N_DOGS SHALL be accepted and ignored.
REQ-023 A kick accepted in the same cycle as frame_tick SHALL be applied before that frame's MOVE.
REQ-024 frame_tick while busy SHALL be dropped and pulse overrun for one cycle.
REQ-025 Collision: pair overlaps if |xi-xj| < BOX_W and |yi-yj| < BOX_H.
REQ-026 On overlap, both hits counters increment (saturating at 255), and velx/vely of i and j are swapped.

Reset
REQ-027 On rst, dog i SHALL reset to posx=100+64*i, posy=100+32*i, velx=+384 (i even) / -384 (i odd), vely=256, hits=0.
REQ-028 On rst, busy, frame_done and overrun SHALL be 0, and the FSM SHALL be in IDLE.
REQ-029 rst mid-frame SHALL abort the frame with no frame_done pulse.

Configuration
REQ-030 Macro DOG_COLLIDE_EN defined: COLLIDE state and pair logic present.
REQ-031 Macro DOG_COLLIDE_EN undefined: MOVE -> DONE directly, P=0, and hits_flat stays 0.

Structure
REQ-032 Package game_pkg SHALL hold FRAC_BITS=8, VEL_W=10, VEL_MIN/VEL_MAX, the FSM state enum, and the reset-position constants.
REQ-033 Sub-module dog_integrator SHALL be the combinational per-axis step (REQ-018..020), instanced twice and time-shared across dogs.

Verification
REQ-034 N_DOGS=1, one tick -> posx=101, posy=101, velx=376, vely=251; frame_done at t+2.
REQ-035 N_DOGS=1, SCREEN_W=160: repeated ticks -> posx never exceeds 112; on the clamp frame velx turns negative and posx=112.
REQ-036 Kick dog0 dvx=+511 twice from reset -> velx=511 (saturated); kick_id=7 with N_DOGS=4 -> no state change.
REQ-037 N_DOGS=2, BOX_W=80, BOX_H=40, DOG_COLLIDE_EN -> after one frame hits0=hits1=1, velx0=-377, velx1=376; frame_done at t+4.
REQ-038 Tick during busy -> overrun pulse and frame unaffected; rst mid-MOVE -> all reset values next cycle, no frame_done.
